// File: rtl/inst_enc_pkg.sv
// Shared definitions for the PU instruction encoder and decoder: request kinds,
// field codes and opcode prefixes, so both sides agree on the word format.
package inst_enc_pkg;

    typedef enum logic [3:0] {
        K_NOP   = 4'd0,
        K_HALT  = 4'd1,
        K_CALRR = 4'd2,
        K_CALRI = 4'd3,
        K_JPREL = 4'd4,
        K_LI16  = 4'd5,
        K_LMRI  = 4'd6,
        K_SMRI  = 4'd7,
        K_CMPI  = 4'd8
    } kind_e;

    localparam int KIND_MAX = 8;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_THB = 3'd2,
        ALU_ASL = 3'd3,
        ALU_RSL = 3'd4,
        ALU_RSR = 3'd5,
        ALU_NAD = 3'd6,
        ALU_XOR = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        FF_UC = 2'd0,
        FF_ZE = 2'd1,
        FF_CA = 2'd2,
        FF_SG = 2'd3
    } flag_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EMIT,
        S_EMIT_LO,
        S_EMIT_HI,
        S_STOP
    } state_e;

    localparam logic [15:0] WORD_NOP  = 16'h0000;
    localparam logic [15:0] WORD_HALT = 16'h0001;

    localparam logic [5:0] PFX_CALRR = 6'b000010;
    localparam logic [2:0] PFX_CALRI = 3'b001;
    localparam logic [2:0] PFX_JPREL = 3'b010;
    localparam logic [3:0] PFX_LI    = 4'b1000;
    localparam logic [3:0] PFX_LMRI  = 4'b1010;
    localparam logic [3:0] PFX_SMRI  = 4'b1011;
    localparam logic [3:0] PFX_CMPI  = 4'b1111;

    localparam logic [1:0] LI_LO_SEL  = 2'b10;
    localparam logic [1:0] LI_HI_SEL  = 2'b11;
    localparam logic [1:0] JPREL_MID  = 2'b11;
    localparam logic [1:0] CMPI_MID   = 2'b00;

    // LIL and LIH differ only in the half-select bits and which immediate byte they carry.
    function automatic logic [15:0] enc_li(input logic [1:0] rw, input logic hi, input logic [7:0] b);
        return {PFX_LI, rw, (hi ? LI_HI_SEL : LI_LO_SEL), b};
    endfunction

endpackage

// File: rtl/inst_enc_if.sv
// Request and instruction-word bus of the encoder; slave is the encoder side,
// master is the requester / imem loader side.
interface inst_enc_if #(
    parameter int ADDRW = 8,
    parameter int KINDW = 4
);
    logic             req_vld;
    logic             req_rdy;
    logic [KINDW-1:0] req_kind;
    logic [1:0]       req_rw;
    logic [1:0]       req_ra;
    logic [1:0]       req_rb;
    logic [2:0]       req_op;
    logic             req_sub;
    logic [1:0]       req_ff;
    logic             req_p;
    logic [15:0]      req_imm;
    logic [15:0]      iw;
    logic             iw_vld;
    logic             iw_rdy;
    logic [ADDRW-1:0] ia;
    logic             done;
    logic             err;

    modport master (
        output req_vld, req_kind, req_rw, req_ra, req_rb, req_op, req_sub,
               req_ff, req_p, req_imm, iw_rdy,
        input  req_rdy, iw, iw_vld, ia, done, err
    );

    modport slave (
        input  req_vld, req_kind, req_rw, req_ra, req_rb, req_op, req_sub,
               req_ff, req_p, req_imm, iw_rdy,
        output req_rdy, iw, iw_vld, ia, done, err
    );
endinterface

// File: rtl/inst_enc_pack.sv
// Combinational packer: request kind and fields to one 16-bit PU word, plus the
// LI16 marker and an immediate range / invalid-kind error flag.
module inst_pack
    import inst_enc_pkg::*;
#(
    parameter int KINDW = 4
) (
    input  logic [KINDW-1:0] kind,
    input  logic [1:0]       rw,
    input  logic [1:0]       ra,
    input  logic [1:0]       rb,
    input  logic [2:0]       op,
    input  logic             sub,
    input  logic [1:0]       ff,
    input  logic             p,
    input  logic [15:0]      imm,
    output logic [15:0]      word,
    output logic             is_li16,
    output logic             range_err
);

    logic  sext_ok;
    logic  zext_ok;
    logic  kind_ok;
    kind_e k;

    // Out-of-range immediates still produce a word, just with the low byte kept.
    always_comb begin
        sext_ok   = (imm[15:8] == {8{imm[7]}});
        zext_ok   = (imm[15:8] == 8'h00);
        kind_ok   = (kind <= KINDW'(KIND_MAX));
        k         = kind_e'(kind[3:0]);
        word      = WORD_NOP;
        is_li16   = 1'b0;
        range_err = 1'b0;
        case (k)
            K_NOP:   word = WORD_NOP;
            K_HALT:  word = WORD_HALT;
            K_CALRR: word = {PFX_CALRR, rw, 1'b0, op, ra, rb};
            K_CALRI: begin
                word      = {PFX_CALRI, sub, rw, ra, imm[7:0]};
                range_err = ~zext_ok;
            end
            K_JPREL: begin
                word      = {PFX_JPREL, p, JPREL_MID, ff, imm[7:0]};
                range_err = ~sext_ok;
            end
            K_LI16: begin
                word    = enc_li(rw, 1'b0, imm[7:0]);
                is_li16 = 1'b1;
            end
            K_LMRI: begin
                word      = {PFX_LMRI, rw, ra, imm[7:0]};
                range_err = ~sext_ok;
            end
            K_SMRI: begin
                word      = {PFX_SMRI, ra, rb, imm[7:0]};
                range_err = ~sext_ok;
            end
            K_CMPI: begin
                word      = {PFX_CMPI, ra, CMPI_MID, imm[7:0]};
                range_err = ~sext_ok;
            end
            default: range_err = 1'b1;
        endcase
        if (!kind_ok) begin
            word      = WORD_NOP;
            is_li16   = 1'b0;
            range_err = 1'b1;
        end
    end

endmodule

// File: rtl/inst_enc.sv
// Instruction encoder: accepts structured requests, streams packed PU words with
// an incrementing imem address, splitting LI16 into LIL then LIH.
module inst_enc
    import inst_enc_pkg::*;
#(
    parameter int ADDRW = 8,
    parameter int KINDW = 4
) (
    input  logic      clk,
    input  logic      rst,
    inst_enc_if.slave bus
);

    state_e           state;
    state_e           state_nxt;
    logic [15:0]      iw_q;
    logic [15:0]      lih_q;
    logic             halt_q;
    logic [ADDRW-1:0] ia_q;
    logic             done_q;
    logic             err_q;
    logic             req_rdy;
    logic             iw_vld;
    logic             accept;
    logic             hs;
    logic [15:0]      pk_word;
    logic             pk_li16;
    logic             pk_err;

    inst_pack #(.KINDW(KINDW)) u_pack (
        .kind      (bus.req_kind),
        .rw        (bus.req_rw),
        .ra        (bus.req_ra),
        .rb        (bus.req_rb),
        .op        (bus.req_op),
        .sub       (bus.req_sub),
        .ff        (bus.req_ff),
        .p         (bus.req_p),
        .imm       (bus.req_imm),
        .word      (pk_word),
        .is_li16   (pk_li16),
        .range_err (pk_err)
    );

    assign accept = bus.req_vld & req_rdy;
    assign hs     = iw_vld & bus.iw_rdy;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Back-to-back requests load straight over a word that leaves this cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) state_nxt = pk_li16 ? S_EMIT_LO : S_EMIT;
            end
            S_EMIT, S_EMIT_HI: begin
                if (hs) begin
                    if (halt_q && state == S_EMIT) state_nxt = S_STOP;
                    else if (accept)               state_nxt = pk_li16 ? S_EMIT_LO : S_EMIT;
                    else                           state_nxt = S_IDLE;
                end
            end
            S_EMIT_LO: begin
                if (hs) state_nxt = S_EMIT_HI;
            end
            S_STOP:  state_nxt = S_STOP;
            default: state_nxt = S_IDLE;
        endcase
    end

    // A held HALT blocks new requests so nothing slips in behind it.
    always_comb begin
        req_rdy = 1'b0;
        iw_vld  = 1'b0;
        case (state)
            S_IDLE: req_rdy = 1'b1;
            S_EMIT: begin
                iw_vld  = 1'b1;
                req_rdy = bus.iw_rdy & ~halt_q;
            end
            S_EMIT_HI: begin
                iw_vld  = 1'b1;
                req_rdy = bus.iw_rdy;
            end
            S_EMIT_LO: iw_vld = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            iw_q   <= WORD_NOP;
            lih_q  <= WORD_NOP;
            halt_q <= 1'b0;
            ia_q   <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            if (accept) begin
                iw_q   <= pk_word;
                lih_q  <= enc_li(bus.req_rw, 1'b1, bus.req_imm[15:8]);
                halt_q <= (bus.req_kind == KINDW'(K_HALT));
                err_q  <= err_q | pk_err;
            end else if (hs && state == S_EMIT_LO) begin
                iw_q <= lih_q;
            end
            if (hs) ia_q <= ia_q + 1'b1;
            if (hs && halt_q && state == S_EMIT) done_q <= 1'b1;
        end
    end

    assign bus.req_rdy = req_rdy;
    assign bus.iw      = iw_q;
    assign bus.iw_vld  = iw_vld;
    assign bus.ia      = ia_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;

endmodule
